// File: rtl/lut_neuron_layer_prog.sv
// Layer of N_NEURONS programmable LUT neurons with a one-deep valid/ready output stage.
// Optional configuration readback port is enabled by defining LUT_READBACK_EN.
module lut_neuron_layer_prog #(
  parameter int unsigned N_NEURONS = 4,
  parameter int unsigned IN_BITS   = 6,
  parameter int unsigned OUT_BITS  = 1,
  parameter int unsigned NID_W     = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_NEURONS*IN_BITS-1:0]  in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N_NEURONS*OUT_BITS-1:0] out_data,
  input  logic                          cfg_we,
  input  logic [NID_W-1:0]              cfg_neuron,
  input  logic [IN_BITS-1:0]            cfg_addr,
  input  logic [OUT_BITS-1:0]           cfg_wdata
`ifdef LUT_READBACK_EN
  ,
  input  logic                          cfg_re,
  output logic                          cfg_rvalid,
  output logic [OUT_BITS-1:0]           cfg_rdata
`endif
);

  localparam int unsigned DEPTH = 2 ** IN_BITS;

  typedef logic [OUT_BITS-1:0] entry_t;

  entry_t lut_q [N_NEURONS][DEPTH];
  entry_t lut_d [N_NEURONS][DEPTH];

  logic                          out_valid_q, out_valid_d;
  logic [N_NEURONS*OUT_BITS-1:0] out_data_q, out_data_d;
  logic [N_NEURONS*OUT_BITS-1:0] lookup;
  logic                          accept;

  // Indices at or above N_NEURONS match no table, so such writes are dropped.
  always_comb begin
    lut_d = lut_q;
    if (cfg_we) begin
      for (int unsigned k = 0; k < N_NEURONS; k++) begin
        if (cfg_neuron == NID_W'(k)) begin
          lut_d[k][cfg_addr] = cfg_wdata;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lut_q <= '{default: '0};
    end else begin
      lut_q <= lut_d;
    end
  end

  // Reads the registered tables, so a same-cycle write is seen only by later lookups.
  always_comb begin
    lookup = '0;
    for (int unsigned k = 0; k < N_NEURONS; k++) begin
      lookup[k*OUT_BITS +: OUT_BITS] = lut_q[k][in_data[k*IN_BITS +: IN_BITS]];
    end
  end

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = lookup;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef LUT_READBACK_EN
  logic                rvalid_q;
  logic [OUT_BITS-1:0] rdata_q, rdata_d;

  // Out-of-range neuron reads return zero but still respond.
  always_comb begin
    rdata_d = rdata_q;
    if (cfg_re) begin
      rdata_d = '0;
      for (int unsigned k = 0; k < N_NEURONS; k++) begin
        if (cfg_neuron == NID_W'(k)) begin
          rdata_d = lut_q[k][cfg_addr];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= cfg_re;
      rdata_q  <= rdata_d;
    end
  end

  assign cfg_rvalid = rvalid_q;
  assign cfg_rdata  = rdata_q;
`endif

endmodule

// File: tb/tb_lut_neuron_layer_prog.sv
// Randomized self-checking bench for lut_neuron_layer_prog (3-neuron instance).
// Exercises readback checks too when LUT_READBACK_EN is defined.
module tb_lut_neuron_layer_prog;

  localparam int unsigned N     = 3;
  localparam int unsigned IB    = 6;
  localparam int unsigned OB    = 1;
  localparam int unsigned NW    = 2;
  localparam int unsigned DEPTH = 64;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [N*IB-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [N*OB-1:0] out_data;
  logic            cfg_we;
  logic [NW-1:0]   cfg_neuron;
  logic [IB-1:0]   cfg_addr;
  logic [OB-1:0]   cfg_wdata;
`ifdef LUT_READBACK_EN
  logic            cfg_re;
  logic            cfg_rvalid;
  logic [OB-1:0]   cfg_rdata;
`endif

  lut_neuron_layer_prog #(
    .N_NEURONS(N),
    .IN_BITS  (IB),
    .OUT_BITS (OB),
    .NID_W    (NW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .cfg_we    (cfg_we),
    .cfg_neuron(cfg_neuron),
    .cfg_addr  (cfg_addr),
`ifdef LUT_READBACK_EN
    .cfg_wdata (cfg_wdata),
    .cfg_re    (cfg_re),
    .cfg_rvalid(cfg_rvalid),
    .cfg_rdata (cfg_rdata)
`else
    .cfg_wdata (cfg_wdata)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: truth tables, a queue of results awaiting consumption,
  // and the last result loaded into the output (which holds after consumption).
  logic [OB-1:0]   mlut [N][DEPTH];
  logic [N*OB-1:0] exp_q [$];
  logic [N*OB-1:0] m_out;
  bit              m_rvalid;
  logic [OB-1:0]   m_rdata;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N*OB-1:0] model_lookup(input logic [N*IB-1:0] d);
    logic [N*OB-1:0] r;
    for (int k = 0; k < N; k++) r[k*OB +: OB] = mlut[k][d[k*IB +: IB]];
    return r;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < N; k++)
      for (int a = 0; a < DEPTH; a++) mlut[k][a] = '0;
    exp_q.delete();
    m_out    = '0;
    m_rvalid = 1'b0;
    m_rdata  = '0;
  endtask

  // Called at a falling edge with inputs set; advances one clock and checks outputs.
  task automatic tick();
    bit exp_ready;
    bit acc;
    logic [N*OB-1:0] popped;
    #1;
    exp_ready = (exp_q.size() == 0) || out_ready;
    check("in_ready", {63'd0, in_ready}, {63'd0, exp_ready});
    if (!rst_n) begin
      model_clear();
    end else begin
      acc = in_valid && exp_ready;
      if (exp_q.size() != 0 && out_ready) begin
        popped = exp_q.pop_front();
        check("pop_data", 64'(out_data), 64'(popped));
      end
      if (acc) begin
        m_out = model_lookup(in_data);
        exp_q.push_back(m_out);
      end
`ifdef LUT_READBACK_EN
      m_rvalid = cfg_re;
      if (cfg_re) m_rdata = (int'(cfg_neuron) < N) ? mlut[cfg_neuron][cfg_addr] : '0;
`endif
      if (cfg_we && int'(cfg_neuron) < N) mlut[cfg_neuron][cfg_addr] = cfg_wdata;
    end
    @(negedge clk);
    check("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() != 0});
    check("out_data", 64'(out_data), 64'(m_out));
`ifdef LUT_READBACK_EN
    check("cfg_rvalid", {63'd0, cfg_rvalid}, {63'd0, m_rvalid});
    if (m_rvalid) check("cfg_rdata", 64'(cfg_rdata), 64'(m_rdata));
`endif
  endtask

  task automatic set_idle();
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_data   = '0;
    cfg_we    = 1'b0;
    cfg_neuron = '0;
    cfg_addr  = '0;
    cfg_wdata = '0;
`ifdef LUT_READBACK_EN
    cfg_re    = 1'b0;
`endif
  endtask

  function automatic bit pattern(input int a);
    return a == 6 || a == 38 || a == 46 || a == 7 || a == 39 || a == 47;
  endfunction

  initial begin
    logic [N*IB-1:0] held;
    set_idle();
    rst_n = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);

    // Reset, then idle and random traffic against the cleared tables.
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = (N*IB)'($urandom);
      tick();
    end
    in_valid = 1'b0;
    tick();

    // Program neuron 0 with the six-hot pattern, then sweep all its addresses.
    for (int a = 0; a < DEPTH; a++) begin
      cfg_we     = 1'b1;
      cfg_neuron = '0;
      cfg_addr   = IB'(a);
      cfg_wdata  = OB'(pattern(a));
      tick();
    end
    cfg_we = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      in_valid = 1'b1;
      in_data  = (N*IB)'($urandom);
      in_data[IB-1:0] = IB'(a);
      tick();
      check("sweep_n0", {63'd0, out_data[0]}, {63'd0, pattern(a)});
      check("sweep_others", 64'(out_data[N*OB-1:OB]), 64'd0);
    end
    in_valid = 1'b0;
    tick();

    // Backpressure: output must hold while stalled, nothing lost on release.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = (N*IB)'($urandom);
      tick();
      if (i == 0) held = out_data;
      check("stall_ready", {63'd0, in_ready}, 64'd0);
      check("stall_hold", 64'(out_data), 64'(held));
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = ($urandom % 2) == 0;
      in_data  = (N*IB)'($urandom);
      tick();
    end
    in_valid = 1'b0;
    tick();

    // Same-cycle write and accept of neuron 1 addr 5: old value first, new value after.
    cfg_we     = 1'b1;
    cfg_neuron = NW'(1);
    cfg_addr   = IB'(5);
    cfg_wdata  = OB'(1);
    in_valid   = 1'b1;
    in_data    = (N*IB)'($urandom);
    in_data[IB +: IB] = IB'(5);
    tick();
    check("collide_old", {63'd0, out_data[1]}, 64'd0);
    cfg_we = 1'b0;
    tick();
    check("collide_new", {63'd0, out_data[1]}, 64'd1);
    in_valid = 1'b0;
    tick();

    // Writes to the nonexistent neuron 3 must leave every table untouched.
    for (int i = 0; i < 16; i++) begin
      cfg_we     = 1'b1;
      cfg_neuron = NW'(3);
      cfg_addr   = IB'($urandom);
      cfg_wdata  = OB'($urandom);
      in_valid   = 1'b1;
      in_data    = (N*IB)'($urandom);
      tick();
    end
    cfg_we = 1'b0;

    // Mixed random traffic with writes, reads and random backpressure.
    for (int i = 0; i < 400; i++) begin
      in_valid   = ($urandom % 4) != 0;
      out_ready  = ($urandom % 3) != 0;
      in_data    = (N*IB)'($urandom);
      cfg_we     = ($urandom % 3) == 0;
      cfg_neuron = NW'($urandom_range(0, 3));
      cfg_addr   = IB'($urandom);
      cfg_wdata  = OB'($urandom);
`ifdef LUT_READBACK_EN
      cfg_re     = ($urandom % 4) == 0;
`endif
      tick();
    end

    // Reset mid-stream, then confirm every table reads as zero.
    in_valid  = 1'b1;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    tick();
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    set_idle();
    for (int a = 0; a < DEPTH; a++) begin
      in_valid = 1'b1;
      in_data  = {IB'(a), IB'(a), IB'(a)};
      tick();
      check("rst_cleared", 64'(out_data), 64'd0);
    end
    in_valid = 1'b0;
    tick();

`ifdef LUT_READBACK_EN
    for (int a = 0; a < DEPTH; a++) begin
      cfg_re     = 1'b1;
      cfg_neuron = NW'($urandom_range(0, N - 1));
      cfg_addr   = IB'(a);
      tick();
      check("rb_cleared", 64'(cfg_rdata), 64'd0);
    end
    cfg_re = 1'b0;
    // Write then read back addr 63 of every neuron, and an out-of-range read.
    for (int k = 0; k < N; k++) begin
      cfg_we     = 1'b1;
      cfg_neuron = NW'(k);
      cfg_addr   = IB'(63);
      cfg_wdata  = OB'(1);
      tick();
      cfg_we = 1'b0;
      cfg_re = 1'b1;
      tick();
      check("rb_valid", {63'd0, cfg_rvalid}, 64'd1);
      check("rb_data", 64'(cfg_rdata), 64'd1);
      cfg_re = 1'b0;
      tick();
    end
    cfg_re     = 1'b1;
    cfg_neuron = NW'(3);
    tick();
    check("rb_oor", 64'(cfg_rdata), 64'd0);
    cfg_re = 1'b0;
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
